// File: rtl/video_rom_arbiter.sv
// rtl/video_rom_arbiter.sv - two-port byte/word/dword read arbiter for the 512x32 video BIOS ROM
// Sequences ROM enable/ready, splits dword-straddling reads into two ROM reads, returns right-justified data.
module video_rom_arbiter #(
  parameter int ADDR_BITS = 11,
  parameter bit FAIR      = 1'b1
) (
  input  logic                 ib_clk,
  input  logic                 ib_rst,
  input  logic                 a_req,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [1:0]           a_size,
  output logic                 a_ack,
  output logic [31:0]          a_data,
  input  logic                 b_req,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [1:0]           b_size,
  output logic                 b_ack,
  output logic [31:0]          b_data,
  output logic                 rom_en,
  output logic [ADDR_BITS-3:0] rom_addr,
  input  logic                 rom_ready,
  input  logic [31:0]          rom_data
);

  localparam int RA = ADDR_BITS - 2;

  typedef enum logic [2:0] {IDLE, RD0, GAP, RD1, DONE} state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;   // 0 = port A, 1 = port B
  logic                 last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic [31:0]          lo_q, lo_d;
  logic [31:0]          a_data_q, a_data_d;
  logic [31:0]          b_data_q, b_data_d;
  logic [RA-1:0]        rom_addr_q, rom_addr_d;
  logic                 pick_b;
  logic [31:0]          result;
  logic                 load;

  function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
    if (size[1])      return off != 2'd0;
    else if (size[0]) return off == 2'd3;
    else              return 1'b0;
  endfunction

  function automatic logic [31:0] shape(input logic [63:0] hilo, input logic [1:0] off,
                                        input logic [1:0] size);
    logic [63:0] sh;
    sh = hilo >> {off, 3'b000};
    if (size[1])      return sh[31:0];
    else if (size[0]) return {16'h0000, sh[15:0]};
    else              return {24'h000000, sh[7:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    addr_d     = addr_q;
    size_d     = size_q;
    lo_d       = lo_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    rom_addr_d = rom_addr_q;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    rom_en     = 1'b0;
    pick_b     = 1'b0;
    result     = 32'h0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (FAIR) pick_b = b_req && (!a_req || !last_q);
          else      pick_b = !a_req;
          grant_d    = pick_b;
          addr_d     = pick_b ? b_addr : a_addr;
          size_d     = pick_b ? b_size : a_size;
          rom_addr_d = addr_d[ADDR_BITS-1:2];
          state_d    = RD0;
        end
      end
      RD0: begin
        rom_en = 1'b1;
        if (rom_ready) begin
          lo_d = rom_data;
          if (is_split(addr_q[1:0], size_q)) begin
            // Second dword wraps modulo the ROM depth via natural RA-bit overflow.
            rom_addr_d = addr_q[ADDR_BITS-1:2] + {{(RA-1){1'b0}}, 1'b1};
            state_d    = GAP;
          end else begin
            result  = shape({32'h0, rom_data}, addr_q[1:0], size_q);
            load    = 1'b1;
            state_d = DONE;
          end
        end
      end
      GAP: state_d = RD1;
      RD1: begin
        rom_en = 1'b1;
        if (rom_ready) begin
          result  = shape({rom_data, lo_q}, addr_q[1:0], size_q);
          load    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        a_ack   = !grant_q;
        b_ack   = grant_q;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Final data is registered on the last capture edge so it is valid in the ack cycle.
    if (load) begin
      if (grant_q) b_data_d = result;
      else         a_data_d = result;
    end
  end

  always_ff @(posedge ib_clk or posedge ib_rst) begin
    if (ib_rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      size_q     <= 2'b00;
      lo_q       <= 32'h0;
      a_data_q   <= 32'h0;
      b_data_q   <= 32'h0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      lo_q       <= lo_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign a_data   = a_data_q;
  assign b_data   = b_data_q;
  assign rom_addr = rom_addr_q;

endmodule
